// File: rtl/mux_share_arbiter.sv
// Round-robin owner arbiter for the shared 2:1 select mux.
// Grants one source at a time and drives the mux select. There is a one-cycle
// dead gap between owners, and an owner's tenure is capped while the other
// source waits.
module mux_share_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req0,
  input  logic             req1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] handovers
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] handovers_q, handovers_d;

  logic have_win;
  logic win;
  logic own_req;
  logic oth_req;
  logic [7:0] hold_inc;

  // Winner selection and owner/contender request views for the current state
  always_comb begin
    have_win = req0 | req1;
    win      = (req0 & req1) ? ~last_q : req1;
    own_req  = (state_q == OWN1) ? req1 : req0;
    oth_req  = (state_q == OWN1) ? req0 : req1;
    hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
  end

  // Next-state and next-output computation for the arbitration FSM
  always_comb begin
    state_d     = state_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    sel_d       = sel_q;
    last_d      = last_q;
    hold_d      = hold_q;
    handovers_d = handovers_q;
    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        if (en && have_win) begin
          state_d     = win ? OWN1 : OWN0;
          gnt0_d      = ~win;
          gnt1_d      = win;
          sel_d       = win;
          last_d      = win;
          hold_d      = 8'd1;
          handovers_d = handovers_q + 1'b1;
        end
      end
      OWN0, OWN1: begin
        hold_d = hold_inc;
        // >= so a contender arriving after the cap was passed still preempts
        if (!own_req || (oth_req && (hold_q >= MAX_HOLD_C))) begin
          state_d = GAP;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
    busy_d = gnt0_d | gnt1_d;
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b1;
      hold_q      <= '0;
      handovers_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      handovers_q <= handovers_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign handovers = handovers_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural owner model.
module tb_mux_share_arbiter;

  localparam int MAXH = 8;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic          gnt0, gnt1, sel, busy;
  logic [CW-1:0] handovers;

  int errors = 0;
  int checks = 0;

  // Behavioural model: who owns the mux, for how long, who went last
  int m_owner;   // -1 none, else owning source
  int m_tenure;  // cycles the current owner has held the grant
  int m_last;
  int m_sel;
  int m_hand;

  mux_share_arbiter #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy), .handovers(handovers)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_tenure = 0; m_last = 1; m_sel = 0; m_hand = 0;
  endtask

  task automatic model_step(input bit e, input bit r0, input bit r1);
    int w;
    bit mine, other;
    if (m_owner >= 0) begin
      mine  = (m_owner == 0) ? r0 : r1;
      other = (m_owner == 0) ? r1 : r0;
      if (!mine || (other && m_tenure >= MAXH)) m_owner = -1;
      else m_tenure++;
    end else if (e && (r0 || r1)) begin
      if (r0 && r1) w = 1 - m_last;
      else w = r1 ? 1 : 0;
      m_owner = w; m_tenure = 1; m_last = w; m_sel = w;
      m_hand = (m_hand + 1) % (1 << CW);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gnt0"}, gnt0, m_owner == 0);
    check({tag, ".gnt1"}, gnt1, m_owner == 1);
    check({tag, ".sel"}, sel, m_sel);
    check({tag, ".busy"}, busy, m_owner >= 0);
    check({tag, ".handovers"}, handovers, m_hand);
  endtask

  // Drive inputs away from the edge, advance one clock, settle
  task automatic step(input bit e, input bit r0, input bit r1);
    en = e; req0 = r0; req1 = r1;
    @(posedge clk);
    model_step(e, r0, r1);
    #1;
  endtask

  task automatic do_reset(input bit e, input bit r0, input bit r1);
    rst_n = 1'b0;
    en = e; req0 = r0; req1 = r1;
    @(posedge clk); @(posedge clk); #1;
    check("rst.gnt0", gnt0, 0);
    check("rst.gnt1", gnt1, 0);
    check("rst.sel", sel, 0);
    check("rst.busy", busy, 0);
    check("rst.handovers", handovers, 0);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // Invariants: exclusive grants; sel moves only with a new grant after a dead cycle
  logic mon_sel, mon_g0, mon_g1;
  always @(posedge clk) begin
    mon_sel = sel; mon_g0 = gnt0; mon_g1 = gnt1;
    #1;
    if (rst_n) begin
      check("mon.exclusive", gnt0 & gnt1, 0);
      if (sel != mon_sel)
        check("mon.sel_change", {30'd0, mon_g0 | mon_g1, sel ? gnt1 : gnt0}, 1);
    end
  end

  typedef struct {
    bit e, r0, r1;
    bit g0, g1, s;
    int h;
  } vec_t;

  vec_t vecs[19];

  initial begin
    bit r0, r1, e;

    vecs[0]  = '{1, 0, 1, 0, 1, 1, 1};  // req1 only: grant next edge
    vecs[1]  = '{1, 0, 1, 0, 1, 1, 1};
    vecs[2]  = '{1, 0, 1, 0, 1, 1, 1};  // third grant cycle
    vecs[3]  = '{1, 0, 0, 0, 0, 1, 1};  // release -> GAP, sel kept
    vecs[4]  = '{1, 0, 0, 0, 0, 1, 1};  // IDLE
    vecs[5]  = '{0, 1, 0, 0, 0, 1, 1};  // en low blocks grant
    vecs[6]  = '{1, 1, 0, 1, 0, 0, 2};  // en raised -> gnt0
    vecs[7]  = '{0, 1, 0, 1, 0, 0, 2};  // en low does not revoke owner
    vecs[8]  = '{0, 1, 1, 1, 0, 0, 2};
    vecs[9]  = '{0, 0, 1, 0, 0, 0, 2};  // release -> GAP
    vecs[10] = '{0, 0, 1, 0, 0, 0, 2};  // en low in GAP -> IDLE, no grant
    vecs[11] = '{1, 0, 1, 0, 1, 1, 3};
    vecs[12] = '{1, 1, 1, 0, 1, 1, 3};
    vecs[13] = '{1, 0, 0, 0, 0, 1, 3};  // GAP
    vecs[14] = '{1, 1, 1, 1, 0, 0, 4};  // both after GAP, last=1 -> source 0
    vecs[15] = '{1, 0, 0, 0, 0, 0, 4};  // GAP
    vecs[16] = '{1, 1, 0, 1, 0, 0, 5};  // same source re-granted
    vecs[17] = '{1, 0, 0, 0, 0, 0, 5};
    vecs[18] = '{1, 0, 0, 0, 0, 0, 5};

    // Contention from reset: 0 wins first, then alternation under the cap
    do_reset(1, 1, 1);
    step(1, 1, 1);
    check("cont.first_gnt0", gnt0, 1);
    check("cont.first_sel", sel, 0);
    check("cont.first_hand", handovers, 1);
    for (int i = 2; i <= MAXH; i++) begin
      step(1, 1, 1);
      check("cont.hold_gnt0", gnt0, 1);
    end
    step(1, 1, 1);
    check("cont.gap_gnt0", gnt0, 0);
    check("cont.gap_gnt1", gnt1, 0);
    check("cont.gap_sel", sel, 0);
    step(1, 1, 1);
    check("cont.gnt1", gnt1, 1);
    check("cont.sel1", sel, 1);
    check("cont.hand2", handovers, 2);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1);
      check_model("cont");
    end

    // Directed vector table
    do_reset(0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].e, vecs[i].r0, vecs[i].r1);
      check($sformatf("vec%0d.gnt0", i), gnt0, vecs[i].g0);
      check($sformatf("vec%0d.gnt1", i), gnt1, vecs[i].g1);
      check($sformatf("vec%0d.sel", i), sel, vecs[i].s);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].g0 | vecs[i].g1);
      check($sformatf("vec%0d.handovers", i), handovers, vecs[i].h);
    end

    // Lone requester is never preempted, even past the cap
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0);
      check("lone.gnt0", gnt0, 1);
    end
    step(1, 0, 0);
    check("lone.release", busy, 0);
    step(1, 0, 0);

    // Late contender after the cap already passed is served next
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    step(1, 1, 1);
    check("late.gap", busy, 0);
    step(1, 1, 1);
    check("late.gnt1", gnt1, 1);
    check_model("late");

    // Asynchronous reset mid-tenure of gnt1
    do_reset(0, 0, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    check("arst.pre_gnt1", gnt1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.gnt1", gnt1, 0);
    check("arst.sel", sel, 0);
    check("arst.busy", busy, 0);
    check("arst.handovers", handovers, 0);
    #2 rst_n = 1'b1;
    model_reset();
    step(1, 0, 1);
    check("arst.restart_gnt1", gnt1, 1);
    check("arst.restart_hand", handovers, 1);

    // Counter wrap over 256 handovers
    do_reset(0, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      step(1, 1, 0);
      if (i == 255) check("wrap.255", handovers, 255);
      step(1, 0, 0);
    end
    check("wrap.zero", handovers, 0);
    check_model("wrap");

    // Randomized run with sticky requests
    do_reset(0, 0, 0);
    r0 = 0; r1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) r0 = ~r0;
      if ($urandom_range(0, 5) == 0) r1 = ~r1;
      e = ($urandom_range(0, 7) != 0);
      step(e, r0, r1);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
